usb_buffer_arbiter: RTL and testbench
=====================================

// Module: usb_buffer_arbiter
// PURPOSE
//  Arbitrates a single-port byte-addressed data buffer between the AHB-lite slave (tx store / rx get)
//  and the USB packet engines (rx store / tx get). Owns write/read pointers, occupancy count,
//  flush sequencing and overflow/underflow error flags. Sits between the AHB address decoder
//  strobes and the data buffer RAM.
// PARAMETERS
//  DEPTH   64  buffer size in bytes; power of 2
//  ADDR_W  6   log2(DEPTH); pointer width
// PORTS
//  clk           in   1        system clock, rising edge
//  n_rst         in   1        async reset, active low
//  ahb_wr_req    in   1        AHB store request (level; held until ahb_gnt)
//  ahb_rd_req    in   1        AHB get request (level; held until ahb_gnt)
//  ahb_size      in   2        AHB bytes per access: 0=1, 1=2, 2/3=4; sampled with request
//  usb_wr_req    in   1        USB rx byte store request (held until usb_gnt)
//  usb_rd_req    in   1        USB tx byte get request (held until usb_gnt)
//  flush         in   1        single-cycle clear-buffer pulse
//  ahb_gnt       out  1        one-cycle grant to AHB side
//  usb_gnt       out  1        one-cycle grant to USB side
//  buf_wen       out  1        buffer write strobe
//  buf_ren       out  1        buffer read strobe
//  buf_addr      out  ADDR_W   buffer access start address
//  buf_nbytes    out  3        bytes moved this access (1, 2 or 4)
//  occupancy     out  ADDR_W+1 bytes currently held (0..DEPTH)
//  overflow_err  out  1        sticky; write denied because it exceeded free space
//  underflow_err out  1        sticky; read denied because it exceeded occupancy
// BEHAVIOUR
//  - Reset: state IDLE, wptr=rptr=0, occupancy=0, rr=USB, all outputs 0.
//  - FSM (registered) with states IDLE, GRANT and FLUSH.
//    IDLE: flush=1 -> FLUSH. Else if any request -> GRANT. Else stay.
//    GRANT: exactly one cycle. Asserts the winner's gnt and the buffer strobe.
//           Always returns to IDLE, so the same requester is never granted in consecutive cycles.
//    FLUSH: one cycle. wptr=rptr=occupancy=0 and both err flags cleared. Then IDLE.
//  - flush arriving in GRANT is latched and taken on the following IDLE cycle.
//  - All gnt and strobe outputs are registered. Request-to-grant latency is 1 cycle from IDLE.
//  - Arbitration happens in IDLE across the sides that have a request.
//    Round-robin: rr points to the preferred side; after a grant, rr points to the other side.
//    Within a side, wr_req and rd_req high together: wr wins. A requester never asserts both.
//  - Byte count n: AHB uses ahb_size; USB is always 1.
//  - Write: if occupancy+n > DEPTH, no strobe, no pointer change, overflow_err set.
//    gnt is still pulsed so the requester releases.
//    Else buf_wen=1, buf_addr=wptr, wptr+=n mod DEPTH, occupancy+=n.
//  - Read: if n > occupancy, no strobe, underflow_err set, gnt pulsed.
//    Else buf_ren=1, buf_addr=rptr, rptr+=n mod DEPTH, occupancy-=n.
//  - Pointers wrap modulo DEPTH; a multi-byte access may straddle the wrap. The RAM wraps its byte lanes.
//  - occupancy and pointers update on the clock edge ending GRANT; values are valid in the next IDLE.
//  - Error flags clear only on reset or FLUSH.
//  - Reset mid-GRANT: outputs drop asynchronously; the access is lost.
// TESTING
//  - Reset -> all outputs 0, occupancy=0; after release, with no requests, stay IDLE.
//  - ahb_wr_req, ahb_size=2 from empty:
//    -> next cycle ahb_gnt=1, buf_wen=1, buf_addr=0, buf_nbytes=4; then occupancy=4.
//  - ahb_wr_req and usb_rd_req held together, rr=USB:
//    -> usb_gnt first, ahb_gnt exactly 2 cycles later, grants alternate.
//  - 61 bytes stored, then AHB 4-byte write -> ahb_gnt=1, buf_wen=0, overflow_err=1, occupancy stays 61.
//  - wptr=62, 4-byte write then 4-byte read at rptr=62 -> buf_addr=62 both times, pointers wrap to 2.
//  - flush during GRANT -> access completes, FLUSH follows next IDLE, then occupancy=0 and err flags 0.

Source files
------------

// File: rtl/usb_buffer_arbiter_if.sv
// -----------------------------------------------------------------------------
// usb_buffer_arbiter_if
// Purpose : bundles the request/grant handshakes, the flush strobe, the buffer
//           RAM access strobes and the status outputs of usb_buffer_arbiter.
// Modports:
//   master : requester / environment side (drives requests, size, flush;
//            observes grants, buffer strobes and status)
//   slave  : the arbiter itself
// Signals :
//   ahb_wr_req, ahb_rd_req, ahb_size[1:0] - AHB store/get requests and size
//   usb_wr_req, usb_rd_req                - USB rx store / tx get requests
//   flush                                 - single-cycle clear-buffer pulse
//   ahb_gnt, usb_gnt                      - one-cycle grants
//   buf_wen, buf_ren, buf_addr, buf_nbytes- buffer RAM access
//   occupancy, overflow_err, underflow_err- status
// -----------------------------------------------------------------------------
interface usb_buffer_arbiter_if #(
   parameter int ADDR_W = 6
);
   logic              ahb_wr_req;
   logic              ahb_rd_req;
   logic [1:0]        ahb_size;
   logic              usb_wr_req;
   logic              usb_rd_req;
   logic              flush;
   logic              ahb_gnt;
   logic              usb_gnt;
   logic              buf_wen;
   logic              buf_ren;
   logic [ADDR_W-1:0] buf_addr;
   logic [2:0]        buf_nbytes;
   logic [ADDR_W:0]   occupancy;
   logic              overflow_err;
   logic              underflow_err;

   modport master (
      output ahb_wr_req, ahb_rd_req, ahb_size, usb_wr_req, usb_rd_req, flush,
      input  ahb_gnt, usb_gnt, buf_wen, buf_ren, buf_addr, buf_nbytes,
      input  occupancy, overflow_err, underflow_err
   );

   modport slave (
      input  ahb_wr_req, ahb_rd_req, ahb_size, usb_wr_req, usb_rd_req, flush,
      output ahb_gnt, usb_gnt, buf_wen, buf_ren, buf_addr, buf_nbytes,
      output occupancy, overflow_err, underflow_err
   );
endinterface

// File: rtl/usb_buffer_arbiter.sv
// -----------------------------------------------------------------------------
// usb_buffer_arbiter
// Purpose : arbitrates a single-port byte-addressed data buffer between the
//           AHB-lite slave (tx store / rx get) and the USB packet engines
//           (rx store / tx get). Owns the write/read pointers, occupancy count,
//           flush sequencing and sticky overflow/underflow flags.
// Ports   :
//   clk   - system clock, rising edge
//   n_rst - asynchronous reset, active low
//   bus   - usb_buffer_arbiter_if.slave (requests, grants, buffer strobes,
//           status; see the interface header)
// Parameters:
//   DEPTH  - buffer size in bytes (power of 2)
//   ADDR_W - log2(DEPTH)
// -----------------------------------------------------------------------------
module usb_buffer_arbiter #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic                  clk,
   input  logic                  n_rst,
   usb_buffer_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   localparam logic [ADDR_W+1:0] LP_DEPTH = (ADDR_W+2)'(DEPTH);

   state_t            r_state;
   state_t            w_state_next;

   logic [ADDR_W-1:0] r_wptr;
   logic [ADDR_W-1:0] r_rptr;
   logic [ADDR_W:0]   r_occ;
   logic              r_rr;          // 0 = USB preferred, 1 = AHB preferred
   logic              r_flush_pend;
   logic              r_ovf_err;
   logic              r_unf_err;

   // registered grant / strobe outputs
   logic              r_ahb_gnt;
   logic              r_usb_gnt;
   logic              r_buf_wen;
   logic              r_buf_ren;
   logic [ADDR_W-1:0] r_buf_addr;
   logic [2:0]        r_buf_nbytes;
   logic              r_deny_ovf;    // current grant is a refused write
   logic              r_deny_unf;    // current grant is a refused read

   logic              w_ahb_any;
   logic              w_usb_any;
   logic              w_pick_ahb;
   logic              w_is_wr;
   logic [2:0]        w_nbytes;
   logic [ADDR_W+1:0] w_n_ext;
   logic [ADDR_W+1:0] w_occ_ext;
   logic              w_fits;
   logic              w_avail;
   logic              w_take_grant;

   logic              w_ahb_gnt_next;
   logic              w_usb_gnt_next;
   logic              w_buf_wen_next;
   logic              w_buf_ren_next;
   logic [ADDR_W-1:0] w_buf_addr_next;
   logic [2:0]        w_buf_nbytes_next;
   logic              w_deny_ovf_next;
   logic              w_deny_unf_next;

   // ---------------------------------------------------------------------
   // Arbitration and access qualification, evaluated while IDLE
   // ---------------------------------------------------------------------
   assign w_ahb_any  = bus.ahb_wr_req | bus.ahb_rd_req;
   assign w_usb_any  = bus.usb_wr_req | bus.usb_rd_req;
   assign w_pick_ahb = w_ahb_any & (~w_usb_any | r_rr);
   // write wins if a side ever shows both requests
   assign w_is_wr    = w_pick_ahb ? bus.ahb_wr_req : bus.usb_wr_req;

   always_comb begin
      w_nbytes = 3'd1;
      if (w_pick_ahb) begin
         case (bus.ahb_size)
            2'd0:    w_nbytes = 3'd1;
            2'd1:    w_nbytes = 3'd2;
            default: w_nbytes = 3'd4;
         endcase
      end
   end

   // one extra bit so occupancy + 4 cannot wrap before the compare
   assign w_n_ext   = (ADDR_W+2)'(w_nbytes);
   assign w_occ_ext = (ADDR_W+2)'(r_occ);
   assign w_fits    = (w_occ_ext + w_n_ext) <= LP_DEPTH;
   assign w_avail   = w_n_ext <= w_occ_ext;

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_next = S_IDLE;
      case (r_state)
         S_IDLE: begin
            if (bus.flush || r_flush_pend) begin
               w_state_next = S_FLUSH;
            end else if (w_ahb_any || w_usb_any) begin
               w_state_next = S_GRANT;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_GRANT: w_state_next = S_IDLE;
         S_FLUSH: w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   assign w_take_grant = (r_state == S_IDLE) && (w_state_next == S_GRANT);

   // ---------------------------------------------------------------------
   // FSM: output logic (values loaded into the output registers; all zero
   // except on the IDLE->GRANT transition, so GRANT lasts one cycle)
   // ---------------------------------------------------------------------
   always_comb begin
      w_ahb_gnt_next    = 1'b0;
      w_usb_gnt_next    = 1'b0;
      w_buf_wen_next    = 1'b0;
      w_buf_ren_next    = 1'b0;
      w_buf_addr_next   = '0;
      w_buf_nbytes_next = 3'd0;
      w_deny_ovf_next   = 1'b0;
      w_deny_unf_next   = 1'b0;
      if (w_take_grant) begin
         w_ahb_gnt_next = w_pick_ahb;
         w_usb_gnt_next = ~w_pick_ahb;
         if (w_is_wr) begin
            if (w_fits) begin
               w_buf_wen_next    = 1'b1;
               w_buf_addr_next   = r_wptr;
               w_buf_nbytes_next = w_nbytes;
            end else begin
               w_deny_ovf_next   = 1'b1;
            end
         end else begin
            if (w_avail) begin
               w_buf_ren_next    = 1'b1;
               w_buf_addr_next   = r_rptr;
               w_buf_nbytes_next = w_nbytes;
            end else begin
               w_deny_unf_next   = 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Output registers, pointers, occupancy, round-robin and error flags
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_ahb_gnt    <= 1'b0;
         r_usb_gnt    <= 1'b0;
         r_buf_wen    <= 1'b0;
         r_buf_ren    <= 1'b0;
         r_buf_addr   <= '0;
         r_buf_nbytes <= 3'd0;
         r_deny_ovf   <= 1'b0;
         r_deny_unf   <= 1'b0;
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_occ        <= '0;
         r_rr         <= 1'b0;
         r_flush_pend <= 1'b0;
         r_ovf_err    <= 1'b0;
         r_unf_err    <= 1'b0;
      end else begin
         r_ahb_gnt    <= w_ahb_gnt_next;
         r_usb_gnt    <= w_usb_gnt_next;
         r_buf_wen    <= w_buf_wen_next;
         r_buf_ren    <= w_buf_ren_next;
         r_buf_addr   <= w_buf_addr_next;
         r_buf_nbytes <= w_buf_nbytes_next;
         r_deny_ovf   <= w_deny_ovf_next;
         r_deny_unf   <= w_deny_unf_next;

         // the loser of this round becomes the preferred side
         if (w_take_grant) begin
            r_rr <= ~w_pick_ahb;
         end

         // a flush seen during GRANT is held until the next IDLE takes it
         if (w_state_next == S_FLUSH) begin
            r_flush_pend <= 1'b0;
         end else if ((r_state == S_GRANT) && bus.flush) begin
            r_flush_pend <= 1'b1;
         end

         if (r_state == S_FLUSH) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_occ     <= '0;
            r_ovf_err <= 1'b0;
            r_unf_err <= 1'b0;
         end else if (r_state == S_GRANT) begin
            // commit the access on the edge that ends GRANT
            if (r_buf_wen) begin
               r_wptr <= r_wptr + ADDR_W'(r_buf_nbytes);
               r_occ  <= r_occ + (ADDR_W+1)'(r_buf_nbytes);
            end
            if (r_buf_ren) begin
               r_rptr <= r_rptr + ADDR_W'(r_buf_nbytes);
               r_occ  <= r_occ - (ADDR_W+1)'(r_buf_nbytes);
            end
            if (r_deny_ovf) begin
               r_ovf_err <= 1'b1;
            end
            if (r_deny_unf) begin
               r_unf_err <= 1'b1;
            end
         end
      end
   end

   assign bus.ahb_gnt       = r_ahb_gnt;
   assign bus.usb_gnt       = r_usb_gnt;
   assign bus.buf_wen       = r_buf_wen;
   assign bus.buf_ren       = r_buf_ren;
   assign bus.buf_addr      = r_buf_addr;
   assign bus.buf_nbytes    = r_buf_nbytes;
   assign bus.occupancy     = r_occ;
   assign bus.overflow_err  = r_ovf_err;
   assign bus.underflow_err = r_unf_err;

endmodule

// File: tb/tb_usb_buffer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_usb_buffer_arbiter
// Directed stimulus for usb_buffer_arbiter. Each request pushes its expected
// grant/strobe response into a queue; an independent monitor pops and compares
// whenever a grant appears. Status (occupancy, error flags) is checked at
// hand-computed points.
// -----------------------------------------------------------------------------
module tb_usb_buffer_arbiter;

   logic clk   = 1'b0;
   logic n_rst = 1'b0;

   always #5 clk = ~clk;

   usb_buffer_arbiter_if #(.ADDR_W(6)) bus ();

   usb_buffer_arbiter #(
      .DEPTH  (64),
      .ADDR_W (6)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus.slave)
   );

   typedef struct {
      bit ahb;
      bit wen;
      bit ren;
      int addr;
      int nb;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic void check(string name, int act, int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      exp_t e;
      if (n_rst && (bus.ahb_gnt || bus.usb_gnt)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_gnt", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("gnt_ahb",    int'(bus.ahb_gnt),    int'(e.ahb));
            check("gnt_usb",    int'(bus.usb_gnt),    int'(!e.ahb));
            check("buf_wen",    int'(bus.buf_wen),    int'(e.wen));
            check("buf_ren",    int'(bus.buf_ren),    int'(e.ren));
            check("buf_addr",   int'(bus.buf_addr),   e.addr);
            check("buf_nbytes", int'(bus.buf_nbytes), e.nb);
            $display("grant ahb=%0b wen=%0b ren=%0b addr=%0d nbytes=%0d occ=%0d",
                     bus.ahb_gnt, bus.buf_wen, bus.buf_ren, bus.buf_addr,
                     bus.buf_nbytes, bus.occupancy);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drop_reqs();
      bus.ahb_wr_req = 1'b0;
      bus.ahb_rd_req = 1'b0;
      bus.usb_wr_req = 1'b0;
      bus.usb_rd_req = 1'b0;
   endtask

   // single request; returns on the negedge where its grant is visible
   task automatic req(input bit ahb, input bit wr, input int size,
                      input bit ewen, input bit eren, input int eaddr,
                      input int enb, input bit flush_in_grant);
      exp_t e;
      int   waited;
      e.ahb = ahb; e.wen = ewen; e.ren = eren; e.addr = eaddr; e.nb = enb;
      exp_q.push_back(e);
      @(negedge clk);
      if (ahb) begin
         bus.ahb_size   = 2'(size);
         bus.ahb_wr_req = wr;
         bus.ahb_rd_req = !wr;
      end else begin
         bus.usb_wr_req = wr;
         bus.usb_rd_req = !wr;
      end
      waited = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (ahb ? bus.ahb_gnt : bus.usb_gnt) begin
            waited = i;
            break;
         end
      end
      drop_reqs();
      check("grant_latency", waited, 1);
      if (waited == 0) exp_q.delete();
      if (flush_in_grant) begin
         bus.flush = 1'b1;
         @(negedge clk);
         bus.flush = 1'b0;
      end
   endtask

   task automatic status(input string tag, input int occ, input int ovf, input int unf);
      @(negedge clk);
      check({tag, "_occupancy"}, int'(bus.occupancy),     occ);
      check({tag, "_overflow"},  int'(bus.overflow_err),  ovf);
      check({tag, "_underflow"}, int'(bus.underflow_err), unf);
   endtask

   // AHB 4-byte write and USB 1-byte read raised together
   task automatic pair_req(input bit ahb_first, input int ahb_addr, input int usb_addr);
      exp_t ea, eu;
      int   t_ahb, t_usb;
      ea.ahb = 1; ea.wen = 1; ea.ren = 0; ea.addr = ahb_addr; ea.nb = 4;
      eu.ahb = 0; eu.wen = 0; eu.ren = 1; eu.addr = usb_addr; eu.nb = 1;
      if (ahb_first) begin exp_q.push_back(ea); exp_q.push_back(eu); end
      else           begin exp_q.push_back(eu); exp_q.push_back(ea); end
      @(negedge clk);
      bus.ahb_size   = 2'd2;
      bus.ahb_wr_req = 1'b1;
      bus.usb_rd_req = 1'b1;
      t_ahb = 0; t_usb = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (bus.ahb_gnt) begin t_ahb = i; bus.ahb_wr_req = 1'b0; end
         if (bus.usb_gnt) begin t_usb = i; bus.usb_rd_req = 1'b0; end
         if (t_ahb != 0 && t_usb != 0) break;
      end
      drop_reqs();
      check("pair_first_cycle",  ahb_first ? t_ahb : t_usb, 1);
      check("pair_second_cycle", ahb_first ? t_usb : t_ahb, 3);
      if (t_ahb == 0 || t_usb == 0) exp_q.delete();
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      drop_reqs();
      bus.ahb_size = 2'd0;
      bus.flush    = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_gnts",    int'({bus.ahb_gnt, bus.usb_gnt}), 0);
      check("rst_strobes", int'({bus.buf_wen, bus.buf_ren}), 0);
      check("rst_addr",    int'(bus.buf_addr), 0);
      check("rst_nbytes",  int'(bus.buf_nbytes), 0);
      status("rst", 0, 0, 0);
      n_rst = 1'b1;
      repeat (3) @(negedge clk);
      status("idle", 0, 0, 0);

      // first AHB 4-byte write from empty
      req(1, 1, 2, 1, 0, 0, 4, 0);
      status("first_wr", 4, 0, 0);

      // contention with rr = USB: USB read first, AHB write two cycles later
      pair_req(0, 4, 0);
      status("pair", 7, 0, 0);

      // fill to 61: 13 x 4 bytes at 8..56, then 2 bytes at 60
      for (int k = 0; k < 13; k++) req(1, 1, 2, 1, 0, 8 + 4 * k, 4, 0);
      req(1, 1, 1, 1, 0, 60, 2, 0);
      status("fill61", 61, 0, 0);

      // 4-byte write does not fit: gnt only, overflow set
      req(1, 1, 2, 0, 0, 0, 0, 0);
      status("ovf", 61, 1, 0);

      // exactly full with three USB single-byte writes (62, 63, wrap to 0)
      req(0, 1, 0, 1, 0, 62, 1, 0);
      req(0, 1, 0, 1, 0, 63, 1, 0);
      req(0, 1, 0, 1, 0, 0, 1, 0);
      status("full", 64, 1, 0);
      req(0, 1, 0, 0, 0, 0, 0, 0);
      status("full_deny", 64, 1, 0);

      // flush during GRANT: the 1-byte read at rptr=1 completes, then flush
      req(1, 0, 0, 0, 1, 1, 1, 1);
      @(negedge clk);
      status("flush", 0, 0, 0);

      // walk pointers to 62 and straddle the wrap
      for (int k = 0; k < 15; k++) req(1, 1, 2, 1, 0, 4 * k, 4, 0);
      req(1, 1, 1, 1, 0, 60, 2, 0);
      status("wr62", 62, 0, 0);
      for (int k = 0; k < 15; k++) req(1, 0, 3, 0, 1, 4 * k, 4, 0);
      req(1, 0, 1, 0, 1, 60, 2, 0);
      status("rd62", 0, 0, 0);
      req(1, 1, 2, 1, 0, 62, 4, 0);
      status("wrap_wr", 4, 0, 0);
      req(1, 0, 2, 0, 1, 62, 4, 0);
      status("wrap_rd", 0, 0, 0);
      req(0, 1, 0, 1, 0, 2, 1, 0);
      req(0, 0, 0, 0, 1, 2, 1, 0);
      status("post_wrap", 0, 0, 0);

      // underflow: read from empty
      req(0, 0, 0, 0, 0, 0, 0, 0);
      status("unf", 0, 0, 1);

      // asynchronous reset while GRANT is active
      req(1, 1, 0, 1, 0, 3, 1, 0);
      #1 n_rst = 1'b0;
      #1;
      check("arst_gnt", int'(bus.ahb_gnt), 0);
      check("arst_wen", int'(bus.buf_wen), 0);
      check("arst_unf", int'(bus.underflow_err), 0);
      @(negedge clk);
      n_rst = 1'b1;
      status("after_arst", 0, 0, 0);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
